// File: rtl/cic3_row_readout_ctrl_if.sv
// Readout stream between the CIC3 row sequencer and the chip serialiser.
// Each beat carries one channel word plus its index and frame markers.
interface cic3_row_readout_ctrl_if #(
    parameter int OUT_W = 25,
    parameter int CH_W  = 5
);
    logic             rd_valid;
    logic             rd_ready;
    logic [OUT_W-1:0] rd_data;
    logic [CH_W-1:0]  rd_chan;
    logic             rd_first;
    logic             rd_last;

    modport master (
        output rd_valid,
        output rd_data,
        output rd_chan,
        output rd_first,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_chan,
        input  rd_first,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/cic3_row_readout_ctrl.sv
// Snapshots one CIC3 filter row on each decimation strobe and streams the
// enabled channels out in ascending order, flagging strobes lost to a slow reader.
module cic3_row_readout_ctrl #(
    parameter int NUM_CH = 24,
    parameter int OUT_W  = 25,
    parameter int CH_W   = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    sample_strobe,
    input  logic [NUM_CH*OUT_W-1:0] filt_data,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic                    overrun_clr,
    cic3_row_readout_ctrl_if.master rd,
    output logic                    busy,
    output logic                    overrun,
    output logic [15:0]             frame_cnt
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                         state_q, state_d;
    logic [NUM_CH-1:0]              pend_q, pend_d;
    logic [NUM_CH-1:0][OUT_W-1:0]   snap_q, snap_d;
    logic                           first_q, first_d;
    logic                           overrun_q, overrun_d;
    logic [15:0]                    frame_cnt_q, frame_cnt_d;

    logic [CH_W-1:0]                sel_idx;
    logic [NUM_CH-1:0]              pend_rest;
    logic                           valid;
    logic                           is_last;
    logic                           xfer;
    logic                           last_xfer;
    logic                           start;

    // Lowest pending channel is the one presented on the stream.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) sel_idx = CH_W'(i);
        end
    end

    // Clearing the lowest set bit gives the post-transfer mask in one step.
    assign pend_rest = pend_q & (pend_q - NUM_CH'(1));
    assign valid     = (state_q == SCAN);
    assign is_last   = valid && (pend_rest == '0);
    assign xfer      = valid && rd.rd_ready;
    assign last_xfer = xfer && is_last;
    // A strobe on the final transfer edge counts as arriving in IDLE.
    assign start     = sample_strobe && enable && (|ch_mask) &&
                       ((state_q == IDLE) || last_xfer);

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        snap_d      = snap_q;
        first_d     = first_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;

        if (xfer) begin
            pend_d  = pend_rest;
            first_d = 1'b0;
            if (is_last) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = IDLE;
            end
        end

        if (start) begin
            state_d = SCAN;
            pend_d  = ch_mask;
            snap_d  = filt_data;
            first_d = 1'b1;
        end

        // Setting has priority over a coincident clear.
        if (sample_strobe && (state_q == SCAN) && !last_xfer) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            snap_q      <= '0;
            first_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            snap_q      <= snap_d;
            first_q     <= first_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign rd.rd_valid = valid;
    assign rd.rd_chan  = valid ? sel_idx : '0;
    assign rd.rd_data  = valid ? snap_q[sel_idx] : '0;
    assign rd.rd_first = first_q;
    assign rd.rd_last  = is_last;
    assign busy        = valid;
    assign overrun     = overrun_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cic3_row_readout_ctrl.sv
// Directed bench for cic3_row_readout_ctrl: frames, backpressure, overrun,
// back-to-back frames, ignored strobes and mid-frame reset.
module tb_cic3_row_readout_ctrl;

    localparam int NUM_CH = 24;
    localparam int OUT_W  = 25;
    localparam int CH_W   = 5;

    logic                    clk;
    logic                    reset_n;
    logic                    enable;
    logic                    sample_strobe;
    logic [NUM_CH*OUT_W-1:0] filt_data;
    logic [NUM_CH-1:0]       ch_mask;
    logic                    overrun_clr;
    logic                    busy;
    logic                    overrun;
    logic [15:0]             frame_cnt;

    int tests;
    int fails;

    cic3_row_readout_ctrl_if #(.OUT_W(OUT_W), .CH_W(CH_W)) rd_if ();

    cic3_row_readout_ctrl #(.NUM_CH(NUM_CH), .OUT_W(OUT_W), .CH_W(CH_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_strobe(sample_strobe),
        .filt_data    (filt_data),
        .ch_mask      (ch_mask),
        .overrun_clr  (overrun_clr),
        .rd           (rd_if.master),
        .busy         (busy),
        .overrun      (overrun),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NUM_CH*OUT_W-1:0] pat(input int base);
        logic [NUM_CH*OUT_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) v[k*OUT_W +: OUT_W] = OUT_W'(base + k);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input int ch, input int data,
                              input logic first, input logic last);
        check({tag, " valid"}, 32'(rd_if.rd_valid), 32'd1);
        check({tag, " chan"},  32'(rd_if.rd_chan),  32'(ch));
        check({tag, " data"},  32'(rd_if.rd_data),  32'(data));
        check({tag, " first"}, 32'(rd_if.rd_first), 32'(first));
        check({tag, " last"},  32'(rd_if.rd_last),  32'(last));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " valid"}, 32'(rd_if.rd_valid), 32'd0);
        check({tag, " busy"},  32'(busy),           32'd0);
        check({tag, " chan"},  32'(rd_if.rd_chan),  32'd0);
        check({tag, " data"},  32'(rd_if.rd_data),  32'd0);
        check({tag, " first"}, 32'(rd_if.rd_first), 32'd0);
        check({tag, " last"},  32'(rd_if.rd_last),  32'd0);
    endtask

    int sparse_ch[3];

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        enable = 1'b0;
        sample_strobe = 1'b0;
        filt_data = '0;
        ch_mask = '0;
        overrun_clr = 1'b0;
        rd_if.rd_ready = 1'b0;
        sparse_ch[0] = 0;
        sparse_ch[1] = 2;
        sparse_ch[2] = 23;

        // Reset state
        step();
        step();
        check_quiet("reset");
        check("reset overrun", 32'(overrun), 32'd0);
        check("reset frame_cnt", 32'(frame_cnt), 32'd0);
        reset_n = 1'b1;
        step();

        // Full mask, always ready; input changes during SCAN must not matter
        enable = 1'b1;
        rd_if.rd_ready = 1'b1;
        ch_mask = 24'hFFFFFF;
        filt_data = pat(100);
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        filt_data = pat(500);
        ch_mask = 24'h000001;
        for (int b = 0; b < NUM_CH; b++) begin
            check_beat($sformatf("full b%0d", b), b, 100 + b, b == 0, b == NUM_CH - 1);
            step();
        end
        check_quiet("full end");
        check("full frame_cnt", 32'(frame_cnt), 32'd1);

        // Sparse mask with stalls
        ch_mask = 24'h800005;
        filt_data = pat(200);
        rd_if.rd_ready = 1'b0;
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        ch_mask = 24'h0;
        for (int j = 0; j < 3; j++) begin
            check_beat($sformatf("sparse j%0d", j), sparse_ch[j], 200 + sparse_ch[j], j == 0, j == 2);
            step();
            check_beat($sformatf("sparse stall j%0d", j), sparse_ch[j], 200 + sparse_ch[j], j == 0, j == 2);
            rd_if.rd_ready = 1'b1;
            step();
            rd_if.rd_ready = 1'b0;
        end
        check_quiet("sparse end");
        check("sparse frame_cnt", 32'(frame_cnt), 32'd2);

        // Overrun: second strobe five cycles later while stalled
        ch_mask = 24'hFFFFFF;
        filt_data = pat(300);
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        filt_data = pat(900);
        repeat (4) step();
        check("ovr before", 32'(overrun), 32'd0);
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        check("ovr set", 32'(overrun), 32'd1);
        check_beat("ovr hold", 0, 300, 1'b1, 1'b0);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr clr", 32'(overrun), 32'd0);
        sample_strobe = 1'b1;
        overrun_clr = 1'b1;
        step();
        sample_strobe = 1'b0;
        overrun_clr = 1'b0;
        check("ovr set wins", 32'(overrun), 32'd1);
        rd_if.rd_ready = 1'b1;
        for (int b = 0; b < NUM_CH; b++) begin
            check_beat($sformatf("ovr b%0d", b), b, 300 + b, b == 0, b == NUM_CH - 1);
            step();
        end
        check_quiet("ovr end");
        check("ovr frame_cnt", 32'(frame_cnt), 32'd3);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr clr2", 32'(overrun), 32'd0);

        // Back-to-back frames: strobe on the last transfer edge
        ch_mask = 24'h000003;
        filt_data = pat(400);
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        check_beat("b2b f1 b0", 0, 400, 1'b1, 1'b0);
        step();
        check_beat("b2b f1 b1", 1, 401, 1'b0, 1'b1);
        filt_data = pat(600);
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        check_beat("b2b f2 b0", 0, 600, 1'b1, 1'b0);
        check("b2b overrun", 32'(overrun), 32'd0);
        check("b2b frame_cnt1", 32'(frame_cnt), 32'd4);
        step();
        check_beat("b2b f2 b1", 1, 601, 1'b0, 1'b1);
        step();
        check_quiet("b2b end");
        check("b2b frame_cnt2", 32'(frame_cnt), 32'd5);

        // Ignored strobes
        enable = 1'b0;
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        check_quiet("ign enable");
        enable = 1'b1;
        ch_mask = '0;
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        check_quiet("ign mask");
        check("ign overrun", 32'(overrun), 32'd0);
        check("ign frame_cnt", 32'(frame_cnt), 32'd5);

        // Reset mid-frame after three beats
        ch_mask = 24'hFFFFFF;
        filt_data = pat(100);
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        repeat (3) step();
        check_beat("rst pre", 3, 103, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check_quiet("rst async");
        check("rst frame_cnt", 32'(frame_cnt), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check_quiet("rst idle");
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        check_beat("rst restart", 0, 100, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
